toeplitz_hash: RTL and testbench

- Downstream consumer of the Toeplitz row generator in the privacy-amplification path.
- Buffers one raw-key block of ROW_W bits, loaded in IN_W-bit words.
- For each incoming matrix row, computes one output bit: XOR-reduction of (row AND raw block).
- Packs the OUT_BITS result bits into OUT_W-bit final-key words.

---
 rtl/toeplitz_pkg.sv | 24 ++
 rtl/toeplitz_hash_chunk_parity.sv | 12 +
 rtl/toeplitz_hash.sv | 123 ++++++++++++
 tb/tb_toeplitz_hash.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toeplitz_pkg.sv
// Shared sizes, derived counts and FSM states for the Toeplitz hashing stage.
package toeplitz_pkg;

  localparam int ROW_W    = 3072;
  localparam int CHUNK    = 128;
  localparam int IN_W     = 32;
  localparam int OUT_W    = 32;
  localparam int OUT_BITS = 1024;

  localparam int N_BEATS  = ROW_W / IN_W;
  localparam int N_CHUNKS = ROW_W / CHUNK;

  localparam int BEAT_W   = $clog2(N_BEATS);
  localparam int CHUNK_W  = $clog2(N_CHUNKS);
  localparam int ROWCNT_W = $clog2(OUT_BITS);
  localparam int PACK_W   = $clog2(OUT_W);

  typedef enum logic [1:0] {
    LOAD,
    WAIT_ROW,
    ACCUM
  } state_t;

endpackage

// File: rtl/toeplitz_hash_chunk_parity.sv
// Parity of one CHUNK-wide slice of (row AND raw block); one inner-product step over GF(2).
module chunk_parity
  import toeplitz_pkg::*;
(
  input  logic [CHUNK-1:0] i_row,
  input  logic [CHUNK-1:0] i_raw,
  output logic             o_parity
);

  assign o_parity = ^(i_row & i_raw);

endmodule

// File: rtl/toeplitz_hash.sv
// Buffers one raw-key block, hashes each incoming Toeplitz row down to one bit
// (CHUNK bits per cycle) and packs the bits LSB-first into final-key words.
module toeplitz_hash
  import toeplitz_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic             raw_valid,
  input  logic [IN_W-1:0]  raw_data,
  output logic             raw_ready,
  input  logic             sum_en,
  input  logic [ROW_W-1:0] row,
  output logic             row_ack,
  output logic             key_valid,
  output logic [OUT_W-1:0] key_word,
  output logic             block_done
);

  state_t               r_state;
  logic [ROW_W-1:0]     r_raw;
  logic [ROW_W-1:0]     r_rowReg;
  logic [BEAT_W-1:0]    r_beatCnt;
  logic [CHUNK_W-1:0]   r_chunkIdx;
  logic [ROWCNT_W-1:0]  r_rowCnt;
  logic                 r_acc;
  logic [OUT_W-1:0]     r_packer;
  logic                 r_rawReady;
  logic                 r_keyValid;
  logic [OUT_W-1:0]     r_keyWord;
  logic                 r_blockDone;

  logic                 w_parity;
  logic                 w_finalBit;
  logic [PACK_W-1:0]    w_bitPos;
  logic [OUT_W-1:0]     w_packed;
  logic                 w_rowAck;

  chunk_parity u_chunk_parity (
    .i_row    (r_rowReg[int'(r_chunkIdx)*CHUNK +: CHUNK]),
    .i_raw    (r_raw[int'(r_chunkIdx)*CHUNK +: CHUNK]),
    .o_parity (w_parity)
  );

  // The ack is combinational so upstream sees it in the very cycle its row is latched.
  assign w_rowAck   = (r_state == WAIT_ROW) && sum_en;
  assign w_finalBit = r_acc ^ w_parity;
  assign w_bitPos   = r_rowCnt[PACK_W-1:0];
  assign w_packed   = r_packer | (OUT_W'(w_finalBit) << w_bitPos);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state     <= LOAD;
      r_raw       <= '0;
      r_rowReg    <= '0;
      r_beatCnt   <= '0;
      r_chunkIdx  <= '0;
      r_rowCnt    <= '0;
      r_acc       <= 1'b0;
      r_packer    <= '0;
      r_rawReady  <= 1'b1;
      r_keyValid  <= 1'b0;
      r_keyWord   <= '0;
      r_blockDone <= 1'b0;
    end else begin
      r_keyValid  <= 1'b0;
      r_blockDone <= 1'b0;
      case (r_state)
        LOAD: begin
          if (raw_valid) begin
            r_raw[int'(r_beatCnt)*IN_W +: IN_W] <= raw_data;
            if (r_beatCnt == BEAT_W'(N_BEATS-1)) begin
              r_beatCnt  <= '0;
              r_rawReady <= 1'b0;
              r_state    <= WAIT_ROW;
            end else begin
              r_beatCnt <= r_beatCnt + 1'b1;
            end
          end
        end
        WAIT_ROW: begin
          if (sum_en) begin
            r_rowReg   <= row;
            r_acc      <= 1'b0;
            r_chunkIdx <= '0;
            r_state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (r_chunkIdx != CHUNK_W'(N_CHUNKS-1)) begin
            r_acc      <= w_finalBit;
            r_chunkIdx <= r_chunkIdx + 1'b1;
          end else begin
            // Last slice: the row's hash bit is complete and goes straight into the packer.
            if (w_bitPos == PACK_W'(OUT_W-1)) begin
              r_keyValid <= 1'b1;
              r_keyWord  <= w_packed;
              r_packer   <= '0;
            end else begin
              r_packer <= w_packed;
            end
            if (r_rowCnt == ROWCNT_W'(OUT_BITS-1)) begin
              r_rowCnt    <= '0;
              r_blockDone <= 1'b1;
              r_rawReady  <= 1'b1;
              r_state     <= LOAD;
            end else begin
              r_rowCnt <= r_rowCnt + 1'b1;
              r_state  <= WAIT_ROW;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign raw_ready  = r_rawReady;
  assign row_ack    = w_rowAck;
  assign key_valid  = r_keyValid;
  assign key_word   = r_keyWord;
  assign block_done = r_blockDone;

endmodule

// File: tb/tb_toeplitz_hash.sv
// Randomized bench for toeplitz_hash: each hash bit is predicted as the parity of
// (row AND raw block) and packed LSB-first into expected key words.
module tb_toeplitz_hash;
  import toeplitz_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             raw_valid;
  logic [IN_W-1:0]  raw_data;
  logic             raw_ready;
  logic             sum_en;
  logic [ROW_W-1:0] row;
  logic             row_ack;
  logic             key_valid;
  logic [OUT_W-1:0] key_word;
  logic             block_done;

  toeplitz_hash dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .raw_valid  (raw_valid),
    .raw_data   (raw_data),
    .raw_ready  (raw_ready),
    .sum_en     (sum_en),
    .row        (row),
    .row_ack    (row_ack),
    .key_valid  (key_valid),
    .key_word   (key_word),
    .block_done (block_done)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int ackCount = 0;
  int lastAckCyc = 0;
  int strayDone = 0;
  bit prevDone = 1'b0;
  logic rdyAfterDone = 1'b0;
  logic [OUT_W-1:0] keyQ[$];
  int keyCycQ[$];
  bit doneQ[$];

  logic [ROW_W-1:0] mRaw;
  logic [OUT_W-1:0] mPack;
  int mRowIdx;
  logic [OUT_W-1:0] expQ[$];

  // Observe outputs mid-cycle and log every pulse with its cycle number.
  always @(negedge clk_in) begin
    cyc++;
    if (prevDone) rdyAfterDone = raw_ready;
    prevDone = block_done;
    if (row_ack === 1'b1) begin
      ackCount++;
      lastAckCyc = cyc;
    end
    if (key_valid === 1'b1) begin
      keyQ.push_back(key_word);
      keyCycQ.push_back(cyc);
      doneQ.push_back(block_done);
    end else if (block_done === 1'b1) begin
      strayDone++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 2000000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] rand_vec();
    logic [ROW_W-1:0] v;
    for (int i = 0; i < ROW_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_logs();
    keyQ.delete();
    keyCycQ.delete();
    doneQ.delete();
    expQ.delete();
    strayDone = 0;
    mPack = '0;
    mRowIdx = 0;
    mRaw = '0;
  endtask

  // Reference: bit r of a block is the GF(2) inner product of row r with the raw block.
  task automatic model_add(input logic [ROW_W-1:0] r);
    mPack[mRowIdx % OUT_W] = ^(r & mRaw);
    mRowIdx++;
    if (mRowIdx % OUT_W == 0) begin
      expQ.push_back(mPack);
      mPack = '0;
    end
    if (mRowIdx == OUT_BITS) mRowIdx = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    raw_valid = 1'b0;
    raw_data = '0;
    sum_en = 1'b0;
    row = '0;
    repeat (3) tick();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic load_block(input logic [ROW_W-1:0] blk, input bit gaps);
    for (int b = 0; b < N_BEATS; b++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          tick();
          raw_valid = 1'b0;
        end
      end
      tick();
      raw_valid = 1'b1;
      raw_data = blk[b*IN_W +: IN_W];
    end
    tick();
    raw_valid = 1'b0;
    mRaw = blk;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] r);
    int waited;
    model_add(r);
    row = r;
    sum_en = 1'b1;
    waited = 0;
    @(negedge clk_in);
    while (row_ack !== 1'b1 && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    if (row_ack !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL row_ack_timeout: got no ack, expected ack within 100 cycles");
    end
    tick();
    sum_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [OUT_W+3:0] obs;
    rst = 1'b0;
    raw_valid = 1'b0;
    raw_data = '0;
    sum_en = 1'b1;
    row = rand_vec();
    repeat (3) tick();
    obs = {raw_ready, row_ack, key_valid, block_done, key_word};
    checks++;
    if (obs !== {4'b1000, {OUT_W{1'b0}}}) begin
      failures++;
      $display("[TB] FAIL reset_held: got %h, expected %h", obs, {4'b1000, {OUT_W{1'b0}}});
    end
    sum_en = 1'b0;
    rst = 1'b1;
    clear_logs();
    tick();
    obs = {raw_ready, row_ack, key_valid, block_done, key_word};
    checks++;
    if (obs !== {4'b1000, {OUT_W{1'b0}}}) begin
      failures++;
      $display("[TB] FAIL reset_released: got %h, expected %h", obs, {4'b1000, {OUT_W{1'b0}}});
    end
  endtask

  task automatic test_single_bit_parity();
    logic [ROW_W-1:0] r;
    int a0;
    apply_reset();
    load_block({ROW_W{1'b1}}, 1'b0);
    r = '0;
    r[5] = 1'b1;
    a0 = ackCount;
    send_row(r);
    repeat (5) tick();
    checks++;
    if (ackCount - a0 !== 1) begin
      failures++;
      $display("[TB] FAIL single_ack_count: got %0d, expected 1", ackCount - a0);
    end
    r[3000] = 1'b1;
    send_row(r);
    for (int i = 2; i < OUT_W; i++) send_row(rand_vec());
    repeat (30) tick();
    checks++;
    if (keyQ.size() !== 1) begin
      failures++;
      $display("[TB] FAIL single_key_count: got %0d, expected 1", keyQ.size());
    end else begin
      checks++;
      if (keyQ[0][1:0] !== 2'b01) begin
        failures++;
        $display("[TB] FAIL single_bit_parity: got %b, expected 01", keyQ[0][1:0]);
      end
      checks++;
      if (keyQ[0] !== expQ[0]) begin
        failures++;
        $display("[TB] FAIL single_word: got %h, expected %h", keyQ[0], expQ[0]);
      end
    end
  endtask

  task automatic test_word_packing();
    logic [ROW_W-1:0] blk;
    logic [ROW_W-1:0] r;
    int firstAck;
    apply_reset();
    blk = '0;
    blk[0] = 1'b1;
    load_block(blk, 1'b1);
    firstAck = 0;
    for (int i = 0; i < OUT_W; i++) begin
      r = rand_vec();
      r[0] = (i % 2 == 0);
      send_row(r);
      if (i == 0) firstAck = lastAckCyc;
    end
    repeat (30) tick();
    checks++;
    if (keyQ.size() !== 1) begin
      failures++;
      $display("[TB] FAIL pack_key_count: got %0d, expected 1", keyQ.size());
    end else begin
      checks++;
      if (keyQ[0] !== 32'h5555_5555) begin
        failures++;
        $display("[TB] FAIL pack_word: got %h, expected 55555555", keyQ[0]);
      end
      checks++;
      if (keyCycQ[0] - firstAck !== 800) begin
        failures++;
        $display("[TB] FAIL pack_latency: got %0d, expected 800", keyCycQ[0] - firstAck);
      end
    end
  endtask

  task automatic test_early_row();
    logic [ROW_W-1:0] r;
    int a0;
    apply_reset();
    r = rand_vec();
    row = r;
    sum_en = 1'b1;
    a0 = ackCount;
    load_block(rand_vec(), 1'b1);
    checks++;
    if (ackCount !== a0) begin
      failures++;
      $display("[TB] FAIL early_ack_in_load: got %0d acks, expected 0", ackCount - a0);
    end
    @(negedge clk_in);
    checks++;
    if (row_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL early_ack_after_load: got %b, expected 1", row_ack);
    end
    tick();
    sum_en = 1'b0;
    model_add(r);
    for (int i = 1; i < OUT_W; i++) send_row(rand_vec());
    repeat (30) tick();
    checks++;
    if (keyQ.size() !== 1) begin
      failures++;
      $display("[TB] FAIL early_key_count: got %0d, expected 1", keyQ.size());
    end else begin
      checks++;
      if (keyQ[0] !== expQ[0]) begin
        failures++;
        $display("[TB] FAIL early_word: got %h, expected %h", keyQ[0], expQ[0]);
      end
    end
  endtask

  task automatic test_zero_block();
    apply_reset();
    load_block('0, 1'b0);
    for (int i = 0; i < OUT_W; i++) send_row(rand_vec());
    repeat (30) tick();
    checks++;
    if (keyQ.size() !== 1) begin
      failures++;
      $display("[TB] FAIL zero_key_count: got %0d, expected 1", keyQ.size());
    end else begin
      checks++;
      if (keyQ[0] !== '0) begin
        failures++;
        $display("[TB] FAIL zero_word: got %h, expected 00000000", keyQ[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nDone;
    apply_reset();
    load_block(rand_vec(), 1'b1);
    for (int i = 0; i < OUT_BITS; i++) send_row(rand_vec());
    repeat (30) tick();
    checks++;
    if (keyQ.size() !== OUT_BITS/OUT_W) begin
      failures++;
      $display("[TB] FAIL full_key_count: got %0d, expected %0d", keyQ.size(), OUT_BITS/OUT_W);
    end else begin
      nDone = 0;
      for (int i = 0; i < OUT_BITS/OUT_W; i++) begin
        nDone += doneQ[i];
        checks++;
        if (keyQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL full_word_%0d: got %h, expected %h", i, keyQ[i], expQ[i]);
        end
      end
      checks++;
      if (doneQ[OUT_BITS/OUT_W-1] !== 1'b1 || nDone !== 1 || strayDone !== 0) begin
        failures++;
        $display("[TB] FAIL full_block_done: got last=%0d total=%0d stray=%0d, expected 1 1 0",
                 doneQ[OUT_BITS/OUT_W-1], nDone, strayDone);
      end
      checks++;
      if (rdyAfterDone !== 1'b1) begin
        failures++;
        $display("[TB] FAIL full_ready_after_done: got %b, expected 1", rdyAfterDone);
      end
      repeat (20) tick();
      checks++;
      if (key_word !== expQ[OUT_BITS/OUT_W-1]) begin
        failures++;
        $display("[TB] FAIL full_key_hold: got %h, expected %h", key_word, expQ[OUT_BITS/OUT_W-1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [OUT_W+3:0] obs;
    int a0;
    int waited;
    apply_reset();
    load_block(rand_vec(), 1'b1);
    for (int i = 0; i < 10; i++) send_row(rand_vec());
    row = rand_vec();
    sum_en = 1'b1;
    waited = 0;
    @(negedge clk_in);
    while (row_ack !== 1'b1 && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    if (row_ack !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL mid_row10_ack: got no ack, expected ack within 100 cycles");
    end
    tick();
    sum_en = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    obs = {raw_ready, row_ack, key_valid, block_done, key_word};
    checks++;
    if (obs !== {4'b1000, {OUT_W{1'b0}}}) begin
      failures++;
      $display("[TB] FAIL mid_reset_async: got %h, expected %h", obs, {4'b1000, {OUT_W{1'b0}}});
    end
    tick();
    rst = 1'b1;
    clear_logs();
    a0 = ackCount;
    row = rand_vec();
    sum_en = 1'b1;
    repeat (10) tick();
    sum_en = 1'b0;
    checks++;
    if (ackCount !== a0) begin
      failures++;
      $display("[TB] FAIL mid_ack_in_load: got %0d acks, expected 0", ackCount - a0);
    end
    load_block(rand_vec(), 1'b0);
    for (int i = 0; i < OUT_W-1; i++) send_row(rand_vec());
    repeat (30) tick();
    checks++;
    if (keyQ.size() !== 0) begin
      failures++;
      $display("[TB] FAIL mid_early_key: got %0d keys, expected 0", keyQ.size());
    end
    send_row(rand_vec());
    repeat (30) tick();
    checks++;
    if (keyQ.size() !== 1) begin
      failures++;
      $display("[TB] FAIL mid_key_count: got %0d, expected 1", keyQ.size());
    end else begin
      checks++;
      if (keyQ[0] !== expQ[0]) begin
        failures++;
        $display("[TB] FAIL mid_word: got %h, expected %h", keyQ[0], expQ[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit_parity();
    test_word_packing();
    test_early_row();
    test_zero_block();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
